// File: rtl/mem_pkg.sv
// Shared store-controller types: funct3 encodings, FSM states, lane widths.
package mem_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int LANES   = 4;
    localparam int SMASK_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    function automatic logic [LANES-1:0] base_mask(input logic [2:0] f3);
        logic [LANES-1:0] m;
        case (f3)
            F3_SB:   m = 4'b0001;
            F3_SH:   m = 4'b0011;
            F3_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Shifts the byte mask and store data into lane position across two words.
module store_lane_gen
    import mem_pkg::*;
(
    input  logic [2:0]         i_funct3,
    input  logic [1:0]         i_offset,
    input  logic [31:0]        i_data,
    output logic [SMASK_W-1:0] o_mask,
    output logic [63:0]        o_data
);

    logic [SMASK_W-1:0] w_base;
    logic [4:0]         w_bit_shift;

    assign w_base      = {3'b000, base_mask(i_funct3)};
    assign w_bit_shift = {i_offset, 3'b000};

    assign o_mask = w_base << i_offset;
    assign o_data = {32'h0, i_data} << w_bit_shift;

endmodule

// File: rtl/mem_store_ctrl.sv
// Store controller: sb/sh/sw to byte-lane writes, optional split of misaligned
// stores into two word writes when MISALIGN_SPLIT_EN is defined.
module mem_store_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  misalign_fault
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    logic [SMASK_W-1:0]    w_mask;
    logic [63:0]           w_data;
    logic                  w_split;
    logic                  w_go_hi;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_addr_lo;
    logic [ADDR_WIDTH-1:0] w_addr_hi;

    store_lane_gen u_lane (
        .i_funct3 (r_funct3),
        .i_offset (r_addr[1:0]),
        .i_data   (r_data[31:0]),
        .o_mask   (w_mask),
        .o_data   (w_data)
    );

    assign w_split   = |w_mask[6:4];
    assign w_go_hi   = SPLIT_EN && w_split;
    assign w_addr_lo = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_addr_hi = w_addr_lo + ADDR_WIDTH'(4);

    // WR_LO is only a stall point when a second (high) write must follow.
    assign req_ready = !rst && ((r_state == IDLE) || (r_state == WR_HI) ||
                                ((r_state == WR_LO) && !w_go_hi));
    assign w_hs      = req_valid && req_ready;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_data   <= req_data;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        mem_we         = 4'b0000;
        mem_addr       = '0;
        mem_wdata      = '0;
        done           = 1'b0;
        misalign_fault = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) w_next = WR_LO;
            end
            WR_LO: begin
                mem_addr  = w_addr_lo;
                mem_wdata = w_data[31:0];
                if (w_go_hi) begin
                    mem_we = w_mask[3:0];
                    w_next = WR_HI;
                end else begin
                    // Without split support a lane overflow is dropped, not written.
                    if (w_split) begin
                        misalign_fault = 1'b1;
                    end else begin
                        mem_we = w_mask[3:0];
                        done   = 1'b1;
                    end
                    w_next = w_hs ? WR_LO : IDLE;
                end
            end
            WR_HI: begin
                mem_addr  = w_addr_hi;
                mem_wdata = w_data[63:32];
                mem_we    = {1'b0, w_mask[6:4]};
                done      = 1'b1;
                w_next    = w_hs ? WR_LO : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
